carregador_programa: RTL and testbench
======================================

Name: carregador_programa

Overview:
- Boot-time copy engine that streams a program image out of the instruction disk into instruction memory, one word per cycle.
- It drives the disk's 26-bit address input and receives the disk's 32-bit combinational instruction output.
- It issues registered write strobes to instruction memory.
- The control unit pulses iniciar once before releasing the processor, and the processor is held until concluido.

Parameters:
DISK_SIZE, 200, number of valid disk words; addresses >= DISK_SIZE are illegal
MEM_ADDR_W, 10, instruction-memory address width
LEN_W, 16, width of the word-count input

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
iniciar  in  1  start request, sampled only in OCIOSO
disco_base  in  26  first disk word to copy
mem_base  in  MEM_ADDR_W  first memory address written
tamanho  in  LEN_W  number of words N to copy
disco_endereco  out  26  address driven to the disk (its pc input)
disco_dado  in  32  disk instruction word for disco_endereco, combinational
mem_escrita  out  1  memory write enable
mem_endereco  out  MEM_ADDR_W  memory write address
mem_dado  out  32  memory write data
ocupado  out  1  copy in progress
concluido  out  1  one-cycle pulse when a copy finishes
erro  out  1  sticky range error

Behaviour:
- Clock, reset and arithmetic:
  - One clock domain.
  - reset_n is asynchronous and active-low.
  - On reset all outputs are 0, state is OCIOSO and all counters are cleared.
- States are OCIOSO, COPIA, DRENO and FIM.
- Start acceptance: T is the cycle in which iniciar=1 is sampled in OCIOSO.
  - Range check: disco_base + tamanho is computed at 27 bits and compared against DISK_SIZE.
  - If the sum exceeds DISK_SIZE: erro=1 from T+1 and stays set until the next accepted start. State stays OCIOSO. No writes occur and concluido does not pulse.
  - If N=0 and the range is legal: state goes to FIM, concluido=1 at T+1, no writes, erro cleared.
  - Otherwise: erro is cleared, the read index k is set to 0 and state goes to COPIA.
- COPIA covers cycles T+1 .. T+N.
  - disco_endereco = disco_base + k.
  - At each clock edge, disco_dado is registered into mem_dado, mem_endereco <= mem_base + k, mem_escrita <= 1, and k increments.
  - When k = N-1 has been read, state goes to DRENO.
- DRENO covers cycle T+N+1. The last write is visible. No new disk read occurs. State then goes to FIM.
- Write timing: mem_escrita is high exactly in cycles T+2 .. T+N+1, carrying word k in cycle T+2+k.
- FIM covers cycle T+N+2. concluido=1 and mem_escrita=0. State then returns to OCIOSO.
- ocupado is high in COPIA and DRENO only (T+1 .. T+N+1).
- Start inputs:
  - iniciar is ignored outside OCIOSO.
  - disco_base, mem_base and tamanho are captured at acceptance, so later changes are ignored.
- Memory address arithmetic: mem_endereco wraps modulo 2^MEM_ADDR_W, with no error.
- disco_endereco holds its last value in OCIOSO and FIM.
- Reset mid-copy: all outputs return to 0 asynchronously. Words already written remain in memory. No concluido pulse is generated.
- Back-to-back copies: iniciar held high continuously starts a new copy in the cycle after FIM.

Decomposition:
- Shared package holds:
  - state encoding (OCIOSO=2'd0, COPIA=2'd1, DRENO=2'd2, FIM=2'd3);
  - the DISK_SIZE default;
  - the instruction word width of 32.
- Optional sub-module gerador_endereco: a loadable up-counter with terminal-count flag, instantiated twice (disk index, memory address).
- The FSM and output registers stay in carregador_programa.

Test Plan:
- Reset then start with disco_base=0, mem_base=0, tamanho=16, against the 16-word program image -> mem_escrita high for 16 cycles starting T+2. Memory[0]=32'h58000001 (jump to main), memory[15]=32'h60000000 (halt). concluido at T+18. ocupado high T+1..T+17.
- disco_base=5, mem_base=1020, tamanho=6 -> writes go to 1020,1021,1022,1023,0,1 with disk words 5..10.
- disco_base=190, tamanho=11 -> erro=1 at T+1, no mem_escrita, no concluido. A following legal start with disco_base=190, tamanho=10 clears erro and completes.
- tamanho=0 -> concluido at T+1, mem_escrita never high, ocupado never high.
- iniciar re-pulsed during COPIA with different inputs -> ignored. The original 8-word copy completes unchanged.
- reset_n asserted at T+4 of a 16-word copy -> all outputs 0 immediately. Exactly 2 writes occurred. No concluido. A subsequent copy works normally.

Source files
------------

// File: rtl/carregador_programa_pkg.sv
// Shared definitions for the program loader.
// Holds the FSM state encoding, the default disk size and the instruction word width.
package carregador_programa_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    COPIA  = 2'd1,
    DRENO  = 2'd2,
    FIM    = 2'd3
  } estado_t;

  localparam int DISK_SIZE_PADRAO = 200;
  localparam int PALAVRA_W        = 32;
  localparam int DISCO_ADDR_W     = 26;

endpackage

// File: rtl/carregador_programa_gerador_endereco.sv
// Loadable up-counter with a terminal-count flag.
// Ports:
//   clock, reset_n       clock and asynchronous active-low reset
//   carregar, valor_carga load the counter (load has priority over increment)
//   incrementar          advance the counter by one (wraps modulo 2^W)
//   limite               value at which terminal is raised
//   contagem             current counter value
//   terminal             contagem == limite
module gerador_endereco #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         carregar,
  input  logic [W-1:0] valor_carga,
  input  logic         incrementar,
  input  logic [W-1:0] limite,
  output logic [W-1:0] contagem,
  output logic         terminal
);

  logic [W-1:0] contagem_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contagem_q <= '0;
    end else if (carregar) begin
      contagem_q <= valor_carga;
    end else if (incrementar) begin
      contagem_q <= contagem_q + W'(1);
    end
  end

  assign contagem = contagem_q;
  assign terminal = (contagem_q == limite);

endmodule

// File: rtl/carregador_programa.sv
// Boot-time copy engine: streams tamanho words from the instruction disk
// (starting at disco_base) into instruction memory (starting at mem_base),
// one word per cycle.
// Ports:
//   clock, reset_n                 clock and asynchronous active-low reset
//   iniciar                        start request, honoured only when idle
//   disco_base, mem_base, tamanho  copy parameters, captured at start
//   disco_endereco / disco_dado    disk address out, combinational disk word in
//   mem_escrita/endereco/dado      registered write port to instruction memory
//   ocupado                        copy in progress
//   concluido                      one-cycle pulse at completion
//   erro                           sticky range error (cleared by a legal start)
module carregador_programa
  import carregador_programa_pkg::*;
#(
  parameter int DISK_SIZE  = DISK_SIZE_PADRAO,
  parameter int MEM_ADDR_W = 10,
  parameter int LEN_W      = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    iniciar,
  input  logic [DISCO_ADDR_W-1:0] disco_base,
  input  logic [MEM_ADDR_W-1:0]   mem_base,
  input  logic [LEN_W-1:0]        tamanho,
  output logic [DISCO_ADDR_W-1:0] disco_endereco,
  input  logic [PALAVRA_W-1:0]    disco_dado,
  output logic                    mem_escrita,
  output logic [MEM_ADDR_W-1:0]   mem_endereco,
  output logic [PALAVRA_W-1:0]    mem_dado,
  output logic                    ocupado,
  output logic                    concluido,
  output logic                    erro
);

  estado_t                 estado_q;
  logic [DISCO_ADDR_W-1:0] disco_limite_q;
  logic [MEM_ADDR_W-1:0]   mem_limite_q;
  logic                    mem_escrita_q;
  logic [MEM_ADDR_W-1:0]   mem_endereco_q;
  logic [PALAVRA_W-1:0]    mem_dado_q;
  logic                    ocupado_q;
  logic                    concluido_q;
  logic                    erro_q;

  logic [DISCO_ADDR_W:0]   soma_faixa;
  logic                    fora_faixa;
  logic                    inicia_copia;
  logic [DISCO_ADDR_W-1:0] disco_cnt;
  logic                    disco_terminal;
  logic [MEM_ADDR_W-1:0]   mem_cnt;
  logic                    mem_terminal;
  logic                    fim_copia;

  // One extra bit so a large base plus length cannot wrap into a legal range.
  assign soma_faixa   = {1'b0, disco_base} + (DISCO_ADDR_W+1)'(tamanho);
  assign fora_faixa   = soma_faixa > (DISCO_ADDR_W+1)'(DISK_SIZE);
  assign inicia_copia = (estado_q == OCIOSO) && iniciar && !fora_faixa && (tamanho != '0);

  // The disk counter never wraps inside a legal range, so its terminal is
  // unique; the memory counter's terminal can repeat when the copy wraps
  // memory, so the last word is the cycle where both agree.
  assign fim_copia = disco_terminal && mem_terminal;

  gerador_endereco #(.W(DISCO_ADDR_W)) u_disco (
    .clock       (clock),
    .reset_n     (reset_n),
    .carregar    (inicia_copia),
    .valor_carga (disco_base),
    .incrementar ((estado_q == COPIA) && !fim_copia),
    .limite      (disco_limite_q),
    .contagem    (disco_cnt),
    .terminal    (disco_terminal)
  );

  gerador_endereco #(.W(MEM_ADDR_W)) u_mem (
    .clock       (clock),
    .reset_n     (reset_n),
    .carregar    (inicia_copia),
    .valor_carga (mem_base),
    .incrementar (estado_q == COPIA),
    .limite      (mem_limite_q),
    .contagem    (mem_cnt),
    .terminal    (mem_terminal)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q       <= OCIOSO;
      disco_limite_q <= '0;
      mem_limite_q   <= '0;
      mem_escrita_q  <= 1'b0;
      mem_endereco_q <= '0;
      mem_dado_q     <= '0;
      ocupado_q      <= 1'b0;
      concluido_q    <= 1'b0;
      erro_q         <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (iniciar) begin
            if (fora_faixa) begin
              erro_q <= 1'b1;
            end else if (tamanho == '0) begin
              erro_q      <= 1'b0;
              concluido_q <= 1'b1;
              estado_q    <= FIM;
            end else begin
              erro_q         <= 1'b0;
              ocupado_q      <= 1'b1;
              disco_limite_q <= disco_base + DISCO_ADDR_W'(tamanho) - DISCO_ADDR_W'(1);
              mem_limite_q   <= mem_base + MEM_ADDR_W'(tamanho) - MEM_ADDR_W'(1);
              estado_q       <= COPIA;
            end
          end
        end
        COPIA: begin
          mem_dado_q     <= disco_dado;
          mem_endereco_q <= mem_cnt;
          mem_escrita_q  <= 1'b1;
          if (fim_copia) begin
            estado_q <= DRENO;
          end
        end
        DRENO: begin
          mem_escrita_q <= 1'b0;
          ocupado_q     <= 1'b0;
          concluido_q   <= 1'b1;
          estado_q      <= FIM;
        end
        FIM: begin
          concluido_q <= 1'b0;
          estado_q    <= OCIOSO;
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign disco_endereco = disco_cnt;
  assign mem_escrita    = mem_escrita_q;
  assign mem_endereco   = mem_endereco_q;
  assign mem_dado       = mem_dado_q;
  assign ocupado        = ocupado_q;
  assign concluido      = concluido_q;
  assign erro           = erro_q;

endmodule

// File: tb/tb_carregador_programa.sv
// Self-checking bench for carregador_programa: a behavioural disk image and
// instruction memory surround the DUT; each copy is checked against the
// cycle timeline T+1..T+N+2 and the final memory contents.
module tb_carregador_programa;

  logic        clock;
  logic        reset_n;
  logic        iniciar;
  logic [25:0] disco_base;
  logic [9:0]  mem_base;
  logic [15:0] tamanho;
  logic [25:0] disco_endereco;
  logic [31:0] disco_dado;
  logic        mem_escrita;
  logic [9:0]  mem_endereco;
  logic [31:0] mem_dado;
  logic        ocupado;
  logic        concluido;
  logic        erro;

  int errors = 0;
  int checks = 0;
  int n_escritas = 0;
  bit exp_erro = 0;

  logic [31:0] disco [0:199];
  logic [31:0] imem  [0:1023];

  carregador_programa dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .iniciar        (iniciar),
    .disco_base     (disco_base),
    .mem_base       (mem_base),
    .tamanho        (tamanho),
    .disco_endereco (disco_endereco),
    .disco_dado     (disco_dado),
    .mem_escrita    (mem_escrita),
    .mem_endereco   (mem_endereco),
    .mem_dado       (mem_dado),
    .ocupado        (ocupado),
    .concluido      (concluido),
    .erro           (erro)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  // Combinational disk; illegal addresses read as zero.
  assign disco_dado = (disco_endereco < 26'd200) ? disco[disco_endereco[7:0]] : 32'h0;

  // Instruction memory written through the DUT's write port.
  always @(posedge clock) begin
    if (mem_escrita) begin
      imem[mem_endereco] <= mem_dado;
      n_escritas++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".escrita"},  64'(mem_escrita),    64'd0);
    check({tag, ".ocupado"},  64'(ocupado),        64'd0);
    check({tag, ".concluido"},64'(concluido),      64'd0);
    check({tag, ".erro"},     64'(erro),           64'd0);
    check({tag, ".mem_end"},  64'(mem_endereco),   64'd0);
    check({tag, ".mem_dado"}, 64'(mem_dado),       64'd0);
    check({tag, ".disco_end"},64'(disco_endereco), 64'd0);
  endtask

  // Called at a negedge while idle. Returns at a negedge back in idle.
  task automatic run_copy(input logic [25:0] db, input logic [9:0] mb,
                          input logic [15:0] n, input bit repulse);
    logic [26:0] soma;
    bit err;
    int last;
    bit exp_wr, exp_busy, exp_done;
    logic [9:0] a;
    soma = {1'b0, db} + 27'(n);
    err  = soma > 27'd200;
    last = err ? 3 : int'(n) + 3;
    disco_base = db; mem_base = mb; tamanho = n; iniciar = 1;
    @(posedge clock);
    @(negedge clock);
    iniciar = 0;
    // Inputs after acceptance must have no effect.
    disco_base = 26'($urandom); mem_base = 10'($urandom); tamanho = 16'($urandom);
    exp_erro = err;
    for (int c = 1; c <= last; c++) begin
      if (repulse && c == 3) begin
        iniciar = 1; disco_base = 26'd1; mem_base = 10'd900; tamanho = 16'd3;
      end
      if (repulse && c == 4) iniciar = 0;
      exp_wr   = !err && n != 0 && c >= 2 && c <= int'(n) + 1;
      exp_busy = !err && n != 0 && c <= int'(n) + 1;
      exp_done = !err && ((n == 0) ? (c == 1) : (c == int'(n) + 2));
      check($sformatf("escrita@T+%0d", c),   64'(mem_escrita), 64'(exp_wr));
      check($sformatf("ocupado@T+%0d", c),   64'(ocupado),     64'(exp_busy));
      check($sformatf("concluido@T+%0d", c), 64'(concluido),   64'(exp_done));
      check($sformatf("erro@T+%0d", c),      64'(erro),        64'(exp_erro));
      if (exp_wr) begin
        a = mb + 10'(c - 2);
        check($sformatf("mem_end@T+%0d", c),  64'(mem_endereco), 64'(a));
        check($sformatf("mem_dado@T+%0d", c), 64'(mem_dado),     64'(disco[int'(db) + c - 2]));
      end
      if (!err && n != 0 && c <= int'(n))
        check($sformatf("disco_end@T+%0d", c), 64'(disco_endereco), 64'(db + 26'(c - 1)));
      @(negedge clock);
    end
    if (!err) begin
      for (int i = 0; i < int'(n); i++) begin
        a = mb + 10'(i);
        check($sformatf("imem[%0d]", a), 64'(imem[a]), 64'(disco[int'(db) + i]));
      end
    end
    $display("copy db=%0d mb=%0d n=%0d err=%0b repulse=%0b errors=%0d", db, mb, n, err, repulse, errors);
  endtask

  initial begin
    logic [15:0] rn;
    logic [25:0] rdb;
    reset_n = 0; iniciar = 0; disco_base = 0; mem_base = 0; tamanho = 0;
    for (int i = 0; i < 200; i++) disco[i] = $urandom;
    disco[0]  = 32'h58000001;
    disco[15] = 32'h60000000;
    for (int i = 0; i < 1024; i++) imem[i] = 32'h0;

    #1;
    check_zero_outputs("reset");
    repeat (2) @(negedge clock);
    reset_n = 1;
    @(negedge clock);

    run_copy(26'd0, 10'd0, 16'd16, 0);
    check("imem0_jump", 64'(imem[0]),  64'h58000001);
    check("imem15_halt",64'(imem[15]), 64'h60000000);

    run_copy(26'd5, 10'd1020, 16'd6, 0);
    run_copy(26'd190, 10'd0, 16'd11, 0);
    run_copy(26'd190, 10'd200, 16'd10, 0);
    run_copy(26'd7, 10'd3, 16'd0, 0);
    run_copy(26'd20, 10'd500, 16'd8, 1);
    check("repulse_untouched", 64'(imem[900]), 64'h0);

    // Reset asserted in cycle T+4 of a 16-word copy.
    n_escritas = 0;
    disco_base = 26'd0; mem_base = 10'd100; tamanho = 16'd16; iniciar = 1;
    @(posedge clock);
    @(negedge clock); iniciar = 0;      // T+1
    @(negedge clock);                   // T+2
    @(negedge clock);                   // T+3
    @(negedge clock);                   // T+4
    reset_n = 0;
    #1;
    check_zero_outputs("midreset");
    repeat (3) begin
      @(negedge clock);
      check("midreset.concluido", 64'(concluido), 64'd0);
    end
    check("midreset.writes", 64'(n_escritas), 64'd2);
    check("midreset.w0", 64'(imem[100]), 64'(disco[0]));
    check("midreset.w1", 64'(imem[101]), 64'(disco[1]));
    check("midreset.w2", 64'(imem[102]), 64'h0);
    $display("midreset writes=%0d errors=%0d", n_escritas, errors);
    reset_n = 1;
    exp_erro = 0;
    @(negedge clock);
    run_copy(26'd30, 10'd40, 16'd12, 0);

    for (int r = 0; r < 6; r++) begin
      rn  = 16'($urandom_range(1, 20));
      rdb = 26'($urandom_range(0, 200 - int'(rn)));
      run_copy(rdb, 10'($urandom), rn, 0);
    end
    run_copy(26'($urandom_range(195, 199)), 10'($urandom), 16'($urandom_range(6, 30)), 0);
    run_copy(26'd150, 10'd700, 16'd50, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
